// File: rtl/dma_device_arbiter.sv
// rtl/dma_device_arbiter.sv - round-robin arbiter sharing one DMA controller port among NUM_DEV devices
module dma_device_arbiter #(
    parameter int NUM_DEV = 2,
    parameter int TIMEOUT = 1023,
    parameter int TO_WD   = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_DEV-1:0]     dev_rqst,
    input  logic [NUM_DEV-1:0]     dev_rd_wr,
    input  logic [16*NUM_DEV-1:0]  dev_start_address,
    input  logic [16*NUM_DEV-1:0]  dev_num_words,
    input  logic [16*NUM_DEV-1:0]  dev_wdata,
    input  logic [NUM_DEV-1:0]     dev_ack_in,
    output logic [NUM_DEV-1:0]     dev_dma_ack,
    output logic [NUM_DEV-1:0]     dev_end_flag,
    output logic [NUM_DEV-1:0]     dev_error_flag,
    output logic [15:0]            dev_rdata,
    output logic                   dma_rqst,
    output logic                   dma_rd_wr,
    output logic [15:0]            dma_start_address,
    output logic [15:0]            dma_num_words,
    output logic [15:0]            dma_dev_out,
    output logic                   dma_dev_ack,
    input  logic                   dma_ack,
    input  logic                   dma_end_flag,
    input  logic                   dma_error_flag,
    input  logic [15:0]            dma_dev_in,
    output logic                   busy,
    output logic [1:0]             grant_id
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [TO_WD-1:0] TO_LIM    = TO_WD'(TIMEOUT);
    localparam logic [1:0]       LAST_INIT = 2'(NUM_DEV - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [1:0]       last_grant;
    logic [TO_WD-1:0] to_cnt;

    // Device buses widened to the 4-device maximum so muxing never indexes out of range.
    logic [3:0]  rqst_ext;
    logic [3:0]  rd_wr_ext;
    logic [3:0]  ack_in_ext;
    logic [63:0] addr_ext;
    logic [63:0] nw_ext;
    logic [63:0] wdata_ext;

    assign rqst_ext   = 4'(dev_rqst);
    assign rd_wr_ext  = 4'(dev_rd_wr);
    assign ack_in_ext = 4'(dev_ack_in);
    assign addr_ext   = 64'(dev_start_address);
    assign nw_ext     = 64'(dev_num_words);
    assign wdata_ext  = 64'(dev_wdata);

    // Round-robin pick: first requester after last_grant, wrapping modulo NUM_DEV.
    logic       pick_valid;
    logic [1:0] pick_id;
    logic [2:0] cand;

    always_comb begin
        pick_valid = 1'b0;
        pick_id    = 2'd0;
        cand       = 3'd0;
        for (int k = 1; k <= NUM_DEV; k++) begin
            cand = {1'b0, last_grant} + 3'(k);
            if (cand >= 3'(NUM_DEV)) begin
                cand = cand - 3'(NUM_DEV);
            end
            if (!pick_valid && rqst_ext[cand[1:0]]) begin
                pick_valid = 1'b1;
                pick_id    = cand[1:0];
            end
        end
    end

    logic       in_grant;
    logic       g_rqst;
    logic [5:0] g_base;
    logic       timeout_hit;

    assign in_grant = (state == S_GRANT);
    assign g_rqst   = rqst_ext[grant_id];
    assign g_base   = {grant_id, 4'd0};

    // End, error and withdrawal all outrank the watchdog, so it only fires when nothing else ends the grant.
    assign timeout_hit = (TIMEOUT != 0) && in_grant && g_rqst &&
                         !dma_end_flag && !dma_error_flag && (to_cnt == TO_LIM);

    assign dma_rqst          = in_grant && g_rqst;
    assign dma_rd_wr         = in_grant && rd_wr_ext[grant_id];
    assign dma_start_address = in_grant ? addr_ext[g_base +: 16]  : 16'd0;
    assign dma_num_words     = in_grant ? nw_ext[g_base +: 16]    : 16'd0;
    assign dma_dev_out       = in_grant ? wdata_ext[g_base +: 16] : 16'd0;
    assign dma_dev_ack       = in_grant && ack_in_ext[grant_id];
    assign dev_rdata         = dma_dev_in;
    assign busy              = (state != S_IDLE);

    always_comb begin
        dev_dma_ack    = '0;
        dev_end_flag   = '0;
        dev_error_flag = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (in_grant && (grant_id == 2'(i))) begin
                dev_dma_ack[i]    = dma_ack;
                dev_end_flag[i]   = dma_end_flag;
                dev_error_flag[i] = dma_error_flag || timeout_hit;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (dma_end_flag || dma_error_flag || !g_rqst || timeout_hit) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            grant_id   <= 2'd0;
            last_grant <= LAST_INIT;
            to_cnt     <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && pick_valid) begin
                grant_id   <= pick_id;
                last_grant <= pick_id;
            end
            // Counter only runs while the grant persists; any exit or non-GRANT state parks it at zero.
            if (in_grant && (state_nxt == S_GRANT)) begin
                if (dma_ack) begin
                    to_cnt <= '0;
                end else if (to_cnt != '1) begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dma_device_arbiter.sv
// tb/tb_dma_device_arbiter.sv - directed-vector bench for dma_device_arbiter
module tb_dma_device_arbiter;

    localparam int ND = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [ND-1:0]     dev_rqst;
    logic [ND-1:0]     dev_rd_wr;
    logic [16*ND-1:0]  dev_start_address;
    logic [16*ND-1:0]  dev_num_words;
    logic [16*ND-1:0]  dev_wdata;
    logic [ND-1:0]     dev_ack_in;
    logic [ND-1:0]     dev_dma_ack;
    logic [ND-1:0]     dev_end_flag;
    logic [ND-1:0]     dev_error_flag;
    logic [15:0]       dev_rdata;
    logic              dma_rqst;
    logic              dma_rd_wr;
    logic [15:0]       dma_start_address;
    logic [15:0]       dma_num_words;
    logic [15:0]       dma_dev_out;
    logic              dma_dev_ack;
    logic              dma_ack;
    logic              dma_end_flag;
    logic              dma_error_flag;
    logic [15:0]       dma_dev_in;
    logic              busy;
    logic [1:0]        grant_id;

    dma_device_arbiter #(.NUM_DEV(ND), .TIMEOUT(8), .TO_WD(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .dev_rqst          (dev_rqst),
        .dev_rd_wr         (dev_rd_wr),
        .dev_start_address (dev_start_address),
        .dev_num_words     (dev_num_words),
        .dev_wdata         (dev_wdata),
        .dev_ack_in        (dev_ack_in),
        .dev_dma_ack       (dev_dma_ack),
        .dev_end_flag      (dev_end_flag),
        .dev_error_flag    (dev_error_flag),
        .dev_rdata         (dev_rdata),
        .dma_rqst          (dma_rqst),
        .dma_rd_wr         (dma_rd_wr),
        .dma_start_address (dma_start_address),
        .dma_num_words     (dma_num_words),
        .dma_dev_out       (dma_dev_out),
        .dma_dev_ack       (dma_dev_ack),
        .dma_ack           (dma_ack),
        .dma_end_flag      (dma_end_flag),
        .dma_error_flag    (dma_error_flag),
        .dma_dev_in        (dma_dev_in),
        .busy              (busy),
        .grant_id          (grant_id)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int gap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_rqst(input string tag);
        int n = 0;
        while (dma_rqst !== 1'b1 && n < 20) begin
            tick();
            settle();
            n++;
        end
        chk(tag, 32'(dma_rqst), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset             = 1'b1;
        dev_rqst          = '0;
        dev_rd_wr         = '0;
        dev_start_address = '0;
        dev_num_words     = '0;
        dev_wdata         = '0;
        dev_ack_in        = '0;
        dma_ack           = 1'b0;
        dma_end_flag      = 1'b0;
        dma_error_flag    = 1'b0;
        dma_dev_in        = 16'hA5A5;

        // reset state
        tick(); tick(); settle();
        chk("rst_rqst",  32'(dma_rqst), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_gid",   32'(grant_id), 0);
        chk("rst_rdata", 32'(dev_rdata), 'hA5A5);
        chk("rst_flags", 32'({dev_dma_ack, dev_end_flag, dev_error_flag}), 0);
        tick();
        reset = 1'b0;

        // single requester, dev0 read of 4 words at 0x0200
        tick();
        dev_rqst          = 2'b01;
        dev_rd_wr         = 2'b01;
        dev_start_address = {16'h1234, 16'h0200};
        dev_num_words     = {16'd9, 16'd4};
        dev_wdata         = {16'hBEEF, 16'hCAFE};
        dev_ack_in        = 2'b01;
        settle();
        chk("t1_idle_rqst", 32'(dma_rqst), 0);
        tick(); settle();
        chk("t1_rqst",  32'(dma_rqst), 1);
        chk("t1_busy",  32'(busy), 1);
        chk("t1_gid",   32'(grant_id), 0);
        chk("t1_addr",  32'(dma_start_address), 'h0200);
        chk("t1_nw",    32'(dma_num_words), 4);
        chk("t1_rdwr",  32'(dma_rd_wr), 1);
        chk("t1_wdata", 32'(dma_dev_out), 'hCAFE);
        chk("t1_dack",  32'(dma_dev_ack), 1);
        for (int i = 0; i < 4; i++) begin
            dma_ack = 1'b1;
            settle();
            chk("t1_ack", 32'(dev_dma_ack), 'b01);
            tick();
            dma_ack = 1'b0;
        end
        dma_end_flag = 1'b1;
        settle();
        chk("t1_end", 32'(dev_end_flag), 'b01);
        chk("t1_noerr", 32'(dev_error_flag), 0);
        tick();
        dma_end_flag = 1'b0;
        dev_rqst     = 2'b00;
        settle();
        chk("t1_rel", 32'({dma_rqst, busy, dma_start_address}), 32'({1'b0, 1'b1, 16'h0000}));
        tick(); settle();
        chk("t1_idle", 32'({busy, grant_id}), 0);

        // both requesting from reset: 0,1,0,1 with a 2-cycle request gap
        reset = 1'b1;
        settle();
        dev_rqst = 2'b11;
        tick();
        reset = 1'b0;
        for (int t = 0; t < 4; t++) begin
            wait_rqst("t2_wait");
            chk("t2_order", 32'(grant_id), t % 2);
            dma_end_flag = 1'b1;
            tick();
            dma_end_flag = 1'b0;
            if (t == 3) dev_rqst = 2'b00;
            gap = 0;
            settle();
            while (dma_rqst == 1'b0 && gap < 10) begin
                gap++;
                tick();
                settle();
            end
            if (t < 3) chk("t2_gap", gap, 2);
        end

        // withdrawal: dev1 granted, dev0 pending, dev1 drops after 2 acks
        dev_rqst   = 2'b10;
        dev_ack_in = 2'b10;
        tick(); settle();
        chk("t3_gid",   32'(grant_id), 1);
        chk("t3_addr",  32'(dma_start_address), 'h1234);
        chk("t3_nw",    32'(dma_num_words), 9);
        chk("t3_rdwr",  32'(dma_rd_wr), 0);
        chk("t3_wdata", 32'(dma_dev_out), 'hBEEF);
        chk("t3_dack",  32'(dma_dev_ack), 1);
        dev_rqst = 2'b11;
        for (int i = 0; i < 2; i++) begin
            dma_ack = 1'b1;
            settle();
            chk("t3_ack", 32'(dev_dma_ack), 'b10);
            tick();
            dma_ack = 1'b0;
        end
        dev_rqst = 2'b01;
        settle();
        chk("t3_wd_rqst", 32'(dma_rqst), 0);
        chk("t3_wd_flags", 32'({dev_end_flag, dev_error_flag}), 0);
        tick(); settle();
        chk("t3_rel", 32'({busy, dma_rqst, dev_end_flag, dev_error_flag}), 'b100000);
        tick(); settle();
        tick(); settle();
        chk("t3_next_gid", 32'({grant_id, dma_rqst}), 'b001);
        dma_end_flag = 1'b1;
        tick();
        dma_end_flag = 1'b0;
        dev_rqst     = 2'b00;
        tick();

        // watchdog timeout on dev1: error pulse when the counter reaches 8
        dev_rqst = 2'b10;
        tick(); settle();
        chk("t4_gid", 32'(grant_id), 1);
        chk("t4_pre", 32'({dma_rqst, dev_error_flag}), 'b100);
        for (int i = 1; i < 8; i++) begin
            tick(); settle();
            chk("t4_pre", 32'({dma_rqst, dev_error_flag}), 'b100);
        end
        tick(); settle();
        chk("t4_to_err", 32'(dev_error_flag), 'b10);
        chk("t4_to_end", 32'(dev_end_flag), 0);
        tick(); settle();
        chk("t4_rel", 32'({dma_rqst, dev_error_flag, busy}), 'b0001);
        dev_rqst = 2'b00;
        tick();

        // end coinciding with the timeout cycle: end only
        dev_rqst = 2'b01;
        tick(); settle();
        chk("t5_gid", 32'(grant_id), 0);
        for (int i = 1; i < 8; i++) begin
            tick(); settle();
            chk("t5_pre", 32'({dma_rqst, dev_error_flag}), 'b100);
        end
        tick();
        dma_end_flag = 1'b1;
        settle();
        chk("t5_end", 32'(dev_end_flag), 'b01);
        chk("t5_noerr", 32'(dev_error_flag), 0);
        tick();
        dma_end_flag = 1'b0;
        settle();
        chk("t5_rel", 32'({dma_rqst, dev_error_flag}), 0);
        dev_rqst = 2'b00;
        tick();

        // controller error routed to dev1 only; stray controller inputs while idle
        dev_rqst = 2'b11;
        tick(); settle();
        chk("t6_gid", 32'(grant_id), 1);
        dma_ack = 1'b1;
        settle();
        chk("t6_ack", 32'(dev_dma_ack), 'b10);
        tick();
        dma_ack        = 1'b0;
        dma_error_flag = 1'b1;
        settle();
        chk("t6_err", 32'(dev_error_flag), 'b10);
        chk("t6_noend", 32'(dev_end_flag), 0);
        tick();
        dma_error_flag = 1'b0;
        settle();
        chk("t6_rel", 32'({dma_rqst, busy}), 'b01);
        dev_rqst = 2'b00;
        tick();
        dma_ack        = 1'b1;
        dma_end_flag   = 1'b1;
        dma_error_flag = 1'b1;
        settle();
        chk("t6_stray", 32'({dev_dma_ack, dev_end_flag, dev_error_flag}), 0);
        chk("t6_stray_busy", 32'(busy), 0);
        tick();
        dma_ack        = 1'b0;
        dma_end_flag   = 1'b0;
        dma_error_flag = 1'b0;
        settle();
        chk("t6_idle", 32'(busy), 0);

        // asynchronous reset during dev1 grant
        dev_rqst = 2'b10;
        tick(); settle();
        chk("t7_gid", 32'({grant_id, dma_rqst}), 'b011);
        reset = 1'b1;
        settle();
        chk("t7_rst", 32'({dma_rqst, busy, grant_id}), 0);
        dev_rqst = 2'b11;
        tick();
        reset = 1'b0;
        tick(); settle();
        chk("t7_first", 32'({grant_id, dma_rqst}), 'b001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
